// File: rtl/debounced_wire_pkg.sv
// rtl/debounced_wire_pkg.sv - shared constants, helpers and filter encoding for debounced_wire
//
// Purpose : common definitions imported by debounce_channel and debounced_wire.
//   clog2          constant-function ceiling log2, used to size the per-channel counter
//   DEB_1MS_12MHZ  default debounce length (1 ms at 12 MHz)
//   filt_action_e  per-cycle filter decision; IDLE/COUNTING are implied by the counter value,
//                  COMMIT is the cycle in which out takes the synchronized level
// Optional feature macro: DEBOUNCED_WIRE_EDGE_EN (see debounced_wire.sv)

package debounced_wire_pkg;

   localparam int DEB_1MS_12MHZ = 12000;

   typedef enum logic [1:0] {
      FILT_IDLE     = 2'd0,
      FILT_COUNTING = 2'd1,
      FILT_COMMIT   = 2'd2
   } filt_action_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronizer chain plus debounce filter for a single wire
//
// Purpose : brings one asynchronous input into the clk domain and only lets a new level
//           through after it has been stable for DEBOUNCE_CYCLES synchronized cycles.
// Ports   :
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   in    in   raw asynchronous input
//   out   out  debounced, registered level
//   rise  out  1-cycle pulse in the first cycle out shows 1 (DEBOUNCED_WIRE_EDGE_EN only)
//   fall  out  1-cycle pulse in the first cycle out shows 0 (DEBOUNCED_WIRE_EDGE_EN only)
// Optional feature macro: DEBOUNCED_WIRE_EDGE_EN

module debounce_channel
   import debounced_wire_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = DEB_1MS_12MHZ,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic in,
`ifdef DEBOUNCED_WIRE_EDGE_EN
   output logic rise,
   output logic fall,
`endif
   output logic out
);

   localparam int             CW       = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt_q;
   filt_action_e           action;

   // Raw input is used nowhere except the first flop of this chain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Any cycle where the synchronized level agrees with out restarts the count, so only an
   // unbroken run of DEBOUNCE_CYCLES disagreeing cycles reaches COMMIT.
   always_comb begin
      action = FILT_IDLE;
      if (s != out) begin
         action = (cnt_q == CNT_LAST) ? FILT_COMMIT : FILT_COUNTING;
      end
   end

   // Counter is cleared on COMMIT, so it never exceeds CNT_LAST and cannot wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         out   <= RESET_VAL;
      end else begin
         case (action)
            FILT_COUNTING: cnt_q <= cnt_q + CW'(1);
            FILT_COMMIT: begin
               cnt_q <= '0;
               out   <= s;
            end
            default: cnt_q <= '0;
         endcase
      end
   end

`ifdef DEBOUNCED_WIRE_EDGE_EN
   // Registered on the COMMIT decision so the pulse lines up with the first cycle out
   // shows the new level; equivalent to out & ~out_delayed without an extra compare.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= (action == FILT_COMMIT) &&  s;
         fall <= (action == FILT_COMMIT) && !s;
      end
   end
`endif

endmodule

// File: rtl/debounced_wire.sv
// rtl/debounced_wire.sv - WIDTH-channel synchronizing, debouncing pin-to-logic wire
//
// Purpose : sits directly behind the top-level pins; each bit is an independent
//           debounce_channel, so simultaneous changes commit per channel.
// Ports   :
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset (release expected to be clk-synchronous)
//   in    in   [WIDTH] raw asynchronous inputs
//   out   out  [WIDTH] debounced, registered outputs
//   rise  out  [WIDTH] 0->1 pulses of out (DEBOUNCED_WIRE_EDGE_EN only)
//   fall  out  [WIDTH] 1->0 pulses of out (DEBOUNCED_WIRE_EDGE_EN only)
// Optional feature macro: DEBOUNCED_WIRE_EDGE_EN (adds rise/fall ports and edge flops)

module debounced_wire
   import debounced_wire_pkg::*;
#(
   parameter int   WIDTH           = 1,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = DEB_1MS_12MHZ,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in,
`ifdef DEBOUNCED_WIRE_EDGE_EN
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
`endif
   output logic [WIDTH-1:0] out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL)
      ) u_ch (
         .clk  (clk),
         .rstn (rstn),
         .in   (in[i]),
`ifdef DEBOUNCED_WIRE_EDGE_EN
         .rise (rise[i]),
         .fall (fall[i]),
`endif
         .out  (out[i])
      );
   end

endmodule

// File: tb/tb_debounced_wire.sv
// tb/tb_debounced_wire.sv - self-checking bench for debounced_wire (WIDTH=4, SYNC=2, DEB=4)
`timescale 1ns/1ps

module tb_debounced_wire;

   localparam int W  = 4;
   localparam int SS = 2;
   localparam int DC = 4;

   logic         clk = 1'b0;
   logic         rstn;
   logic [W-1:0] din;
   logic [W-1:0] dout;
`ifdef DEBOUNCED_WIRE_EDGE_EN
   logic [W-1:0] rise;
   logic [W-1:0] fall;
`endif

   always #5 clk = ~clk;

   debounced_wire #(
      .WIDTH           (W),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .RESET_VAL       (1'b0)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .in   (din),
`ifdef DEBOUNCED_WIRE_EDGE_EN
      .rise (rise),
      .fall (fall),
`endif
      .out  (dout)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int           tag;
      logic         rstn;
      logic [W-1:0] in;
      logic [W-1:0] out;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } vec_t;

   vec_t vecs[$];

   task automatic add_n(input int tag, input int n, input logic r, input logic [W-1:0] i,
                        input logic [W-1:0] o, input logic [W-1:0] rs, input logic [W-1:0] fl);
      vec_t v;
      v.tag = tag; v.rstn = r; v.in = i; v.out = o; v.rise = rs; v.fall = fl;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Window rule: out flips at edge k when the synchronized level differed from out on each
   // of the last DC edges and no commit happened inside that window. The synchronized level
   // seen at edge k is the raw input sampled SS edges earlier.
   logic [W-1:0] hist[$];
   logic [W-1:0] shist[$];
   logic [W-1:0] mout, mrise, mfall;
   int           last_commit[W];

   task automatic model_reset();
      hist.delete();
      shist.delete();
      mout = '0; mrise = '0; mfall = '0;
      for (int c = 0; c < W; c++) last_commit[c] = 0;
   endtask

   task automatic model_edge(input logic [W-1:0] vin);
      int           k;
      logic [W-1:0] s;
      logic         ok;
      hist.push_back(vin);
      k = hist.size();
      s = (k >= SS + 1) ? hist[k-1-SS] : '0;
      shist.push_back(s);
      mrise = '0; mfall = '0;
      for (int c = 0; c < W; c++) begin
         if (k - last_commit[c] >= DC) begin
            ok = 1'b1;
            for (int j = 0; j < DC; j++)
               if (shist[k-1-j][c] == mout[c]) ok = 1'b0;
            if (ok) begin
               mout[c] = ~mout[c];
               last_commit[c] = k;
               if (mout[c]) mrise[c] = 1'b1; else mfall[c] = 1'b1;
            end
         end
      end
   endtask

   logic [W-1:0] nin;
   logic         nr;
   int           p;

   initial begin
      rstn = 1'b0;
      din  = 4'hF;
      #1;
      check("reset_state_out", dout, 4'h0);
`ifdef DEBOUNCED_WIRE_EDGE_EN
      check("reset_state_rise", rise, 4'h0);
      check("reset_state_fall", fall, 4'h0);
`endif

      // 1: reset with inputs high, then release
      add_n(1, 2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      add_n(1, 5, 1, 4'hF, 4'h0, 4'h0, 4'h0);
      add_n(1, 1, 1, 4'hF, 4'hF, 4'hF, 4'h0);
      add_n(1, 1, 1, 4'hF, 4'hF, 4'h0, 4'h0);
      // 2: clean step on in[0]
      add_n(2, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add_n(2, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add_n(2, 5, 1, 4'h1, 4'h0, 4'h0, 4'h0);
      add_n(2, 1, 1, 4'h1, 4'h1, 4'h1, 4'h0);
      add_n(2, 1, 1, 4'h1, 4'h1, 4'h0, 4'h0);
      // 3: 3-cycle glitch on in[1]
      add_n(3, 3, 1, 4'h3, 4'h1, 4'h0, 4'h0);
      add_n(3, 8, 1, 4'h1, 4'h1, 4'h0, 4'h0);
      // 4: in[2] bounces every 2 cycles, then holds
      for (int b = 0; b < 2; b++) begin
         add_n(4, 2, 1, 4'h5, 4'h1, 4'h0, 4'h0);
         add_n(4, 2, 1, 4'h1, 4'h1, 4'h0, 4'h0);
      end
      add_n(4, 5, 1, 4'h5, 4'h1, 4'h0, 4'h0);
      add_n(4, 1, 1, 4'h5, 4'h5, 4'h4, 4'h0);
      add_n(4, 1, 1, 4'h5, 4'h5, 4'h0, 4'h0);
      // 5: simultaneous step on in[3] and in[1]
      add_n(5, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      add_n(5, 5, 1, 4'hA, 4'h0, 4'h0, 4'h0);
      add_n(5, 1, 1, 4'hA, 4'hA, 4'hA, 4'h0);
      add_n(5, 1, 1, 4'hA, 4'hA, 4'h0, 4'h0);
      // 6: reset while in[0] is mid-count; count restarts from scratch
      add_n(6, 5, 1, 4'hB, 4'hA, 4'h0, 4'h0);
      add_n(6, 1, 0, 4'hB, 4'h0, 4'h0, 4'h0);
      add_n(6, 5, 1, 4'hB, 4'h0, 4'h0, 4'h0);
      add_n(6, 1, 1, 4'hB, 4'hB, 4'hB, 4'h0);
      add_n(6, 1, 1, 4'hB, 4'hB, 4'h0, 4'h0);
      // 7: all high channels fall together
      add_n(7, 5, 1, 4'h0, 4'hB, 4'h0, 4'h0);
      add_n(7, 1, 1, 4'h0, 4'h0, 4'h0, 4'hB);
      add_n(7, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0);

      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge clk);
         rstn = vecs[n].rstn;
         din  = vecs[n].in;
         @(posedge clk);
         #1;
         check($sformatf("t%0d_v%0d_out", vecs[n].tag, n), dout, vecs[n].out);
`ifdef DEBOUNCED_WIRE_EDGE_EN
         check($sformatf("t%0d_v%0d_rise", vecs[n].tag, n), rise, vecs[n].rise);
         check($sformatf("t%0d_v%0d_fall", vecs[n].tag, n), fall, vecs[n].fall);
`endif
      end

      // ---------------- randomized run against the model ----------------
      @(negedge clk);
      rstn = 1'b0;
      din  = '0;
      @(posedge clk);
      model_reset();
      nin = '0;
      for (int n = 0; n < 900; n++) begin
         p  = (((n / 100) % 3) == 0) ? 1 : (((n / 100) % 3) == 1) ? 3 : 7;
         nr = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, p) == 0) nin[b] = ~nin[b];
         @(negedge clk);
         rstn = nr;
         din  = nin;
         @(posedge clk);
         if (nr) model_edge(nin); else model_reset();
         #1;
         check($sformatf("rand%0d_out", n), dout, mout);
`ifdef DEBOUNCED_WIRE_EDGE_EN
         check($sformatf("rand%0d_rise", n), rise, mrise);
         check($sformatf("rand%0d_fall", n), fall, mfall);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
